traffic_light_ctrl: RTL and testbench

Phase sequencer for one traffic-light approach. It cycles RED -> GREEN -> YELLOW -> RED and reads each phase duration, in seconds, from the Time duration store through that store's set/select/D/Q port. It also owns the write side of that port, so durations can be reprogrammed while the lights are held in a flashing-yellow setup mode. It sits between the 1 Hz tick generator and the lamp drivers / 2-digit countdown display.

---
 rtl/traffic_light_ctrl.sv | 167 ++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Phase sequencer for one traffic-light approach: RED -> GREEN -> YELLOW -> RED,
// with durations read from (and reprogrammed into) the external Time store.
module traffic_light_ctrl #(
  parameter int TW      = 7,
  parameter int MAX_SEC = 99
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          cfg_en,
  input  logic          cfg_wr,
  input  logic [1:0]    cfg_sel,
  input  logic [TW-1:0] cfg_data,
  output logic          tm_set,
  output logic [1:0]    tm_sel,
  output logic [TW-1:0] tm_d,
  input  logic [TW-1:0] tm_q,
  output logic          lamp_r,
  output logic          lamp_y,
  output logic          lamp_g,
  output logic [1:0]    phase,
  output logic [TW-1:0] remaining
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_RED    = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_SETUP  = 3'd4
  } state_t;

  localparam logic [TW-1:0] MAX_V = TW'(MAX_SEC);
  localparam logic [TW-1:0] ONE_V = TW'(1);
  localparam logic [TW-1:0] ZERO_V = TW'(0);

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;

  // A zero duration would stall the sequence, so it is promoted to one second.
  function automatic logic [TW-1:0] load_val(input logic [TW-1:0] q);
    logic [TW-1:0] v;
    if (q == ZERO_V) begin
      v = ONE_V;
    end else if (q > MAX_V) begin
      v = MAX_V;
    end else begin
      v = q;
    end
    return v;
  endfunction

  // State, countdown and blink registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= ZERO_V;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  // Next-state logic: cfg_en outranks tick; tm_q already addresses the next phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (state_q != S_SETUP && cfg_en) begin
      state_d = S_SETUP;
      cnt_d   = ZERO_V;
      blink_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          state_d = S_RED;
          cnt_d   = load_val(tm_q);
        end
        S_RED, S_GREEN, S_YELLOW: begin
          if (tick) begin
            if (cnt_q > ONE_V) begin
              cnt_d = cnt_q - ONE_V;
            end else begin
              cnt_d = load_val(tm_q);
              case (state_q)
                S_RED:   state_d = S_GREEN;
                S_GREEN: state_d = S_YELLOW;
                default: state_d = S_RED;
              endcase
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_SETUP: begin
          if (!cfg_en) begin
            state_d = S_LOAD;
            cnt_d   = ZERO_V;
            blink_d = 1'b0;
          end else if (tick) begin
            blink_d = ~blink_q;
          end else begin
            blink_d = blink_q;
          end
        end
        default: begin
          state_d = S_LOAD;
          cnt_d   = ZERO_V;
          blink_d = 1'b0;
        end
      endcase
    end
  end

  // Output decode: lamps, phase code, countdown and Time store port
  always_comb begin
    lamp_r    = 1'b1;
    lamp_y    = 1'b0;
    lamp_g    = 1'b0;
    phase     = 2'b10;
    remaining = ZERO_V;
    tm_set    = 1'b0;
    tm_sel    = 2'b00;
    tm_d      = ZERO_V;
    case (state_q)
      S_LOAD: begin
        lamp_r = 1'b1;
      end
      S_RED: begin
        phase     = 2'b00;
        remaining = cnt_q;
        tm_sel    = 2'b11;
      end
      S_GREEN: begin
        lamp_r    = 1'b0;
        lamp_g    = 1'b1;
        phase     = 2'b11;
        remaining = cnt_q;
        tm_sel    = 2'b01;
      end
      S_YELLOW: begin
        lamp_r    = 1'b0;
        lamp_y    = 1'b1;
        phase     = 2'b01;
        remaining = cnt_q;
      end
      S_SETUP: begin
        lamp_r = 1'b0;
        lamp_y = blink_q;
        if (cfg_wr && cfg_sel != 2'b10) begin
          tm_set = 1'b1;
          tm_sel = cfg_sel;
          tm_d   = cfg_data;
        end else begin
          tm_set = 1'b0;
        end
      end
      default: begin
        lamp_r = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a behavioural Time duration store.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       cfg_en;
  logic       cfg_wr;
  logic [1:0] cfg_sel;
  logic [6:0] cfg_data;
  logic       tm_set;
  logic [1:0] tm_sel;
  logic [6:0] tm_d;
  logic [6:0] tm_q;
  logic       lamp_r, lamp_y, lamp_g;
  logic [1:0] phase;
  logic [6:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] store [0:3];

  traffic_light_ctrl #(.TW(7), .MAX_SEC(99)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cfg_en(cfg_en), .cfg_wr(cfg_wr),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .tm_set(tm_set), .tm_sel(tm_sel),
    .tm_d(tm_d), .tm_q(tm_q), .lamp_r(lamp_r), .lamp_y(lamp_y), .lamp_g(lamp_g),
    .phase(phase), .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Time store: red at 00, yellow at 01, green at 11
  assign tm_q = store[tm_sel];
  always @(posedge clk) begin
    if (rst) begin
      store[0] <= 7'd35;
      store[1] <= 7'd4;
      store[2] <= 7'd0;
      store[3] <= 7'd25;
    end else if (tm_set) begin
      store[tm_sel] <= tm_d;
    end
  end

  typedef struct {
    logic       en;
    logic       wr;
    logic [1:0] sel;
    logic [6:0] data;
    logic       tk;
    logic [1:0] ph;
    logic [6:0] rem;
    logic [2:0] lamps;
    logic       set;
    logic [1:0] tsel;
    logic [6:0] d;
  } vec_t;

  vec_t vecs [0:8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] ph, input logic [6:0] rem,
                           input logic [2:0] lamps, input logic set, input logic [1:0] tsel,
                           input logic [6:0] d);
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
    chk({tag, ".lamps"}, 32'({lamp_r, lamp_y, lamp_g}), 32'(lamps));
    chk({tag, ".tm_set"}, 32'(tm_set), 32'(set));
    chk({tag, ".tm_sel"}, 32'(tm_sel), 32'(tsel));
    chk({tag, ".tm_d"}, 32'(tm_d), 32'(d));
    chk({tag, ".rg_excl"}, 32'(lamp_r & lamp_g), 32'd0);
  endtask

  task automatic step(input logic en, input logic wr, input logic [1:0] sel,
                      input logic [6:0] data, input logic tk);
    @(negedge clk);
    cfg_en   = en;
    cfg_wr   = wr;
    cfg_sel  = sel;
    cfg_data = data;
    tick     = tk;
    #1;
  endtask

  task automatic run_span(input string tag, input logic [1:0] ph, input int from, input int to,
                          input logic [2:0] lamps, input logic [1:0] tsel);
    for (int k = from; k >= to; k--) begin
      step(1'b0, 1'b0, 2'b00, 7'd0, 1'b1);
      check_out(tag, ph, 7'(k), lamps, 1'b0, tsel, 7'd0);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cfg_en = 1'b0; cfg_wr = 1'b0; cfg_sel = 2'b00; cfg_data = 7'd0;

    //                en    wr    sel    data    tk    ph     rem     lamps   set   tsel   d
    vecs[0] = '{1'b0, 1'b1, 2'b01, 7'd0,  1'b0, 2'b00, 7'd35, 3'b100, 1'b0, 2'b11, 7'd0};
    vecs[1] = '{1'b1, 1'b0, 2'b00, 7'd0,  1'b1, 2'b00, 7'd35, 3'b100, 1'b0, 2'b11, 7'd0};
    vecs[2] = '{1'b1, 1'b1, 2'b01, 7'd0,  1'b0, 2'b10, 7'd0,  3'b000, 1'b1, 2'b01, 7'd0};
    vecs[3] = '{1'b1, 1'b1, 2'b10, 7'd55, 1'b1, 2'b10, 7'd0,  3'b000, 1'b0, 2'b00, 7'd0};
    vecs[4] = '{1'b1, 1'b0, 2'b00, 7'd0,  1'b1, 2'b10, 7'd0,  3'b010, 1'b0, 2'b00, 7'd0};
    vecs[5] = '{1'b1, 1'b0, 2'b00, 7'd0,  1'b0, 2'b10, 7'd0,  3'b000, 1'b0, 2'b00, 7'd0};
    vecs[6] = '{1'b0, 1'b0, 2'b00, 7'd0,  1'b0, 2'b10, 7'd0,  3'b000, 1'b0, 2'b00, 7'd0};
    vecs[7] = '{1'b0, 1'b0, 2'b00, 7'd0,  1'b0, 2'b10, 7'd0,  3'b100, 1'b0, 2'b00, 7'd0};
    vecs[8] = '{1'b0, 1'b0, 2'b00, 7'd0,  1'b0, 2'b00, 7'd35, 3'b100, 1'b0, 2'b11, 7'd0};

    // Reset state, LOAD, then one full cycle with default durations
    @(negedge clk); @(negedge clk);
    #1 check_out("reset", 2'b10, 7'd0, 3'b100, 1'b0, 2'b00, 7'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_out("load", 2'b10, 7'd0, 3'b100, 1'b0, 2'b00, 7'd0);
    run_span("red1", 2'b00, 35, 1, 3'b100, 2'b11);
    run_span("green1", 2'b11, 25, 1, 3'b001, 2'b01);
    run_span("yellow1", 2'b01, 4, 1, 3'b010, 2'b00);
    step(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    check_out("red_wrap", 2'b00, 7'd35, 3'b100, 1'b0, 2'b11, 7'd0);

    // Setup entry, writes (yellow=0, invalid sel ignored), blink, exit
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].en, vecs[i].wr, vecs[i].sel, vecs[i].data, vecs[i].tk);
      check_out($sformatf("vec%0d", i), vecs[i].ph, vecs[i].rem, vecs[i].lamps,
                vecs[i].set, vecs[i].tsel, vecs[i].d);
    end
    run_span("red2", 2'b00, 35, 1, 3'b100, 2'b11);
    run_span("green2", 2'b11, 25, 1, 3'b001, 2'b01);
    run_span("yellow_min", 2'b01, 1, 1, 3'b010, 2'b00);
    step(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    check_out("red_after_min", 2'b00, 7'd35, 3'b100, 1'b0, 2'b11, 7'd0);

    // Clamp: green=120 loads as 99; yellow restored to 4
    step(1'b1, 1'b0, 2'b00, 7'd0, 1'b0);
    check_out("pre_setup", 2'b00, 7'd35, 3'b100, 1'b0, 2'b11, 7'd0);
    step(1'b1, 1'b1, 2'b11, 7'd120, 1'b0);
    check_out("wr_green", 2'b10, 7'd0, 3'b000, 1'b1, 2'b11, 7'd120);
    step(1'b1, 1'b1, 2'b01, 7'd4, 1'b0);
    check_out("wr_yellow", 2'b10, 7'd0, 3'b000, 1'b1, 2'b01, 7'd4);
    step(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    check_out("load2", 2'b10, 7'd0, 3'b100, 1'b0, 2'b00, 7'd0);
    run_span("red3", 2'b00, 35, 1, 3'b100, 2'b11);
    run_span("green_clamp", 2'b11, 99, 11, 3'b001, 2'b01);

    // Setup entry mid-GREEN with a coincident tick
    step(1'b1, 1'b0, 2'b00, 7'd0, 1'b1);
    check_out("green10", 2'b11, 7'd10, 3'b001, 1'b0, 2'b01, 7'd0);
    step(1'b1, 1'b1, 2'b11, 7'd25, 1'b0);
    check_out("mid_setup", 2'b10, 7'd0, 3'b000, 1'b1, 2'b11, 7'd25);
    step(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    check_out("leave_setup", 2'b10, 7'd0, 3'b000, 1'b0, 2'b00, 7'd0);
    step(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    check_out("load3", 2'b10, 7'd0, 3'b100, 1'b0, 2'b00, 7'd0);
    run_span("red4", 2'b00, 35, 1, 3'b100, 2'b11);
    run_span("green4", 2'b11, 25, 1, 3'b001, 2'b01);
    run_span("yellow4", 2'b01, 4, 3, 3'b010, 2'b00);
    step(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    check_out("yellow_hold", 2'b01, 7'd2, 3'b010, 1'b0, 2'b00, 7'd0);

    // Async reset between clock edges mid-YELLOW
    #2 rst = 1'b1;
    #1 check_out("async_rst", 2'b10, 7'd0, 3'b100, 1'b0, 2'b00, 7'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_out("load4", 2'b10, 7'd0, 3'b100, 1'b0, 2'b00, 7'd0);
    step(1'b0, 1'b0, 2'b00, 7'd0, 1'b0);
    check_out("red5", 2'b00, 7'd35, 3'b100, 1'b0, 2'b11, 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
